hub75_scan_driver: RTL and testbench

HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

---
 rtl/hub75_pkg.sv | 28 ++
 rtl/hub75_plane_mux.sv | 27 ++
 rtl/hub75_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and widths for the HUB75 scan driver.
// Holds the FSM state enum, channel count and width helpers.
package hub75_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH,
      DISPLAY
   } state_t;

   // Six colour channels per framebuffer word: r1 g1 b1 r2 g2 b2.
   localparam int NUM_CH    = 6;
   localparam int BPC_DEF   = 2;
   localparam int PIX_W_DEF = NUM_CH * BPC_DEF;

   // Framebuffer word width for a given bits-per-channel.
   function automatic int pix_w(input int bpc);
      return NUM_CH * bpc;
   endfunction

   // Counter width for a range of n values, never below one bit.
   function automatic int cw1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hub75_plane_mux.sv
// Picks bit [plane] of each of the six colour channels in a
// framebuffer word.
// Ports: rd_data (six BPC-bit channels, r1 in the top bits),
//        plane (bit-plane index), pix ({r1,g1,b1,r2,g2,b2}).
module hub75_plane_mux
   import hub75_pkg::*;
#(
   parameter int BPC = 2,
   parameter int PW  = 1
) (
   input  logic [pix_w(BPC)-1:0] rd_data,
   input  logic [PW-1:0]         plane,
   output logic [NUM_CH-1:0]     pix
);

   logic [pix_w(BPC)-1:0] sh;

   // After the shift, bit [plane] of channel i sits at i*BPC.
   always_comb begin
      sh  = rd_data >> plane;
      pix = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pix[i] = sh[i*BPC];
      end
   end

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 LED panel scan driver: binary-coded-modulation refresh of a
// two-half panel from a 1-cycle-latency framebuffer.
// Ports: clk, reset (sync, active-high), enable (sampled at frame
//        start), rd_addr/rd_data (framebuffer {row,col} read),
//        r1..b2 (serial colour), row_sel, led_clk, lat, oe_n,
//        frame_done (one-cycle pulse per frame).
module hub75_scan_driver
   import hub75_pkg::*;
#(
   parameter int COLS      = 32,
   parameter int SCAN_ROWS = 16,
   parameter int BPC       = 2,
   parameter int ON_BASE   = 8
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       enable,
   output logic [$clog2(SCAN_ROWS)+$clog2(COLS)-1:0]  rd_addr,
   input  logic [6*BPC-1:0]                           rd_data,
   output logic                                       r1,
   output logic                                       g1,
   output logic                                       b1,
   output logic                                       r2,
   output logic                                       g2,
   output logic                                       b2,
   output logic [$clog2(SCAN_ROWS)-1:0]               row_sel,
   output logic                                       led_clk,
   output logic                                       lat,
   output logic                                       oe_n,
   output logic                                       frame_done
);

   localparam int RW   = $clog2(SCAN_ROWS);
   localparam int CW   = $clog2(COLS);
   localparam int PW   = cw1(BPC);
   localparam int DMAX = ON_BASE << (BPC - 1);
   localparam int DW   = cw1(DMAX);

   localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(SCAN_ROWS - 1);
   localparam logic [PW-1:0] PLANE_LAST = PW'(BPC - 1);
   localparam logic [CW-1:0] COL_ZERO   = '0;

   state_t               state;
   logic [RW-1:0]        row;
   logic [RW-1:0]        row_nxt;
   logic [CW-1:0]        col;
   logic [CW-1:0]        col_nxt;
   logic                 phase;
   logic [PW-1:0]        plane;
   logic [DW-1:0]        dcnt;
   logic [DW-1:0]        disp_last;
   logic [NUM_CH-1:0]    pix_now;
   logic [NUM_CH-1:0]    pix_q;
   logic [NUM_CH-1:0]    pix_out;

   hub75_plane_mux #(
      .BPC (BPC),
      .PW  (PW)
   ) u_mux (
      .rd_data (rd_data),
      .plane   (plane),
      .pix     (pix_now)
   );

   always_comb begin
      disp_last = DW'((ON_BASE << plane) - 1);
      col_nxt   = col + 1'b1;
      row_nxt   = row + 1'b1;
   end

   // rd_data for column c is stable across both phases of c, so
   // phase 0 shows it live and phase 1 shows the captured copy.
   assign pix_out = (state == SHIFT && !phase) ? pix_now : pix_q;
   assign {r1, g1, b1, r2, g2, b2} = pix_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         phase      <= 1'b0;
         plane      <= '0;
         dcnt       <= '0;
         pix_q      <= '0;
         rd_addr    <= '0;
         row_sel    <= '0;
         led_clk    <= 1'b0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               oe_n    <= 1'b1;
               lat     <= 1'b0;
               led_clk <= 1'b0;
               if (enable) begin
                  state   <= LOAD;
                  row     <= '0;
                  plane   <= '0;
                  rd_addr <= '0;
                  row_sel <= '0;
               end
            end
            LOAD: begin
               state <= SHIFT;
               col   <= '0;
               phase <= 1'b0;
            end
            SHIFT: begin
               if (!phase) begin
                  phase   <= 1'b1;
                  led_clk <= 1'b1;
                  pix_q   <= pix_now;
                  // Prefetch the next column; hold on the last one.
                  if (col != COL_LAST) begin
                     rd_addr <= {row, col_nxt};
                  end
               end else begin
                  phase   <= 1'b0;
                  led_clk <= 1'b0;
                  if (col == COL_LAST) begin
                     state <= LATCH;
                     lat   <= 1'b1;
                  end else begin
                     col <= col_nxt;
                  end
               end
            end
            LATCH: begin
               state <= DISPLAY;
               lat   <= 1'b0;
               oe_n  <= 1'b0;
               dcnt  <= '0;
            end
            DISPLAY: begin
               if (dcnt == disp_last) begin
                  oe_n <= 1'b1;
                  if (plane != PLANE_LAST) begin
                     plane   <= plane + 1'b1;
                     state   <= LOAD;
                     rd_addr <= {row, COL_ZERO};
                     row_sel <= row;
                  end else begin
                     plane <= '0;
                     if (row != ROW_LAST) begin
                        row     <= row_nxt;
                        state   <= LOAD;
                        rd_addr <= {row_nxt, COL_ZERO};
                        row_sel <= row_nxt;
                     end else begin
                        row        <= '0;
                        frame_done <= 1'b1;
                        // row_sel only moves on entry to LOAD.
                        if (enable) begin
                           state   <= LOAD;
                           rd_addr <= '0;
                           row_sel <= '0;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with a 1-cycle-latency RAM.
// Small panel: 4 columns, 2 scan rows, 2 planes, base on-time 2.
module tb_hub75_scan_driver;

   localparam int COLS    = 4;
   localparam int SROWS   = 2;
   localparam int BPC     = 2;
   localparam int ON_BASE = 2;
   // Per row: 2 planes x (1 load + 8 shift + 1 latch) + 2 + 4 on.
   localparam int FRAME   = 52;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [2:0]  rd_addr;
   logic [11:0] rd_data;
   logic        r1, g1, b1, r2, g2, b2;
   logic        row_sel;
   logic        led_clk;
   logic        lat;
   logic        oe_n;
   logic        frame_done;

   logic [11:0] mem [8];

   int n_chk;
   int n_err;
   int cyc;
   int rises;
   int rises_pre;
   int lat_cnt;
   int run;
   int fd_n;
   int t0;
   int rises_mark;
   logic prev_led;
   int runs [$];
   int fd_t [$];
   logic r1_q [$];
   logic g2_q [$];

   // Hand-computed r1 / g2 at each led_clk rise over one frame:
   // order row0 p0, row0 p1, row1 p0, row1 p1; four columns each.
   int r1_exp [16] = '{0,0,1,0, 0,1,1,0, 1,0,0,0, 0,0,0,0};
   int g2_exp [16] = '{0,0,0,0, 0,0,0,0, 0,0,0,1, 0,0,0,0};

   hub75_scan_driver #(
      .COLS      (COLS),
      .SCAN_ROWS (SROWS),
      .BPC       (BPC),
      .ON_BASE   (ON_BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .r1         (r1),
      .g1         (g1),
      .b1         (b1),
      .r2         (r2),
      .g2         (g2),
      .b2         (b2),
      .row_sel    (row_sel),
      .led_clk    (led_clk),
      .lat        (lat),
      .oe_n       (oe_n),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic clr_trk();
      rises     = 0;
      rises_pre = 0;
      lat_cnt   = 0;
      run       = 0;
      fd_n      = 0;
      runs.delete();
      fd_t.delete();
      r1_q.delete();
      g2_q.delete();
      prev_led  = led_clk;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (led_clk && !prev_led) begin
         if (lat_cnt == 0) rises_pre++;
         rises++;
         r1_q.push_back(r1);
         g2_q.push_back(g2);
      end
      prev_led = led_clk;
      if (lat) lat_cnt++;
      if (!oe_n) begin
         run++;
         if (lat_cnt > 0)
            check("row_sel_on", row_sel, ((lat_cnt - 1) / BPC) % SROWS);
      end else if (run > 0) begin
         runs.push_back(run);
         run = 0;
      end
      if (frame_done) begin
         fd_n++;
         fd_t.push_back(cyc);
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      reset  = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      mem[1] = 12'h800;
      mem[2] = 12'hC00;
      mem[4] = 12'h400;
      mem[7] = 12'h004;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_oe_n", oe_n, 1);
      check("rst_lat", lat, 0);
      check("rst_led_clk", led_clk, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_row_sel", row_sel, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_colour", {r1, g1, b1, r2, g2, b2}, 0);

      clr_trk();
      reset  = 1'b0;
      enable = 1'b1;
      step();
      t0 = cyc;
      check("load_rd_addr", rd_addr, 0);
      check("load_oe_n", oe_n, 1);
      check("load_led_clk", led_clk, 0);

      for (int i = 0; i < 400 && fd_n < 2; i++) step();
      check("fd_two_frames", fd_n, 2);
      check("rises_before_lat", rises_pre, 4);
      check("r1_p0_c1", r1_q[1], 0);
      check("r1_p1_c1", r1_q[5], 1);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("r1_rise%0d", i), r1_q[i], r1_exp[i]);
         check($sformatf("g2_rise%0d", i), g2_q[i], g2_exp[i]);
      end
      check("oe_run0", runs[0], 2);
      check("oe_run1", runs[1], 4);
      check("oe_run2", runs[2], 2);
      check("oe_run3", runs[3], 4);
      check("frame1_len", fd_t[0] - t0, FRAME);
      check("frame2_len", fd_t[1] - fd_t[0], FRAME);

      // Drop enable partway into row 1 of the third frame.
      repeat (30) step();
      check("row_sel_mid_row1", row_sel, 1);
      enable = 1'b0;
      for (int i = 0; i < 200 && fd_n < 3; i++) step();
      check("fd_after_drop", fd_n, 3);
      check("frame3_len", fd_t[2] - fd_t[1], FRAME);
      rises_mark = rises;
      repeat (12) step();
      check("idle_fd_count", fd_n, 3);
      check("idle_oe_n", oe_n, 1);
      check("idle_no_shift", rises - rises_mark, 0);

      // Restart, then reset during the row-1 plane-0 display.
      enable = 1'b1;
      for (int i = 0; i < 200 && !(oe_n == 1'b0 && row_sel == 1'b1); i++)
         step();
      check("reach_display_r1", {oe_n, row_sel}, 2'b01);
      reset = 1'b1;
      step();
      check("prst_oe_n", oe_n, 1);
      check("prst_rd_addr", rd_addr, 0);
      check("prst_row_sel", row_sel, 0);
      check("prst_lat", lat, 0);
      check("prst_led_clk", led_clk, 0);
      check("prst_frame_done", frame_done, 0);
      check("prst_colour", {r1, g1, b1, r2, g2, b2}, 0);

      clr_trk();
      reset = 1'b0;
      step();
      check("restart_rd_addr", rd_addr, 0);
      check("restart_oe_n", oe_n, 1);
      for (int i = 0; i < 100 && runs.size() < 1; i++) step();
      check("restart_rises", rises_pre, 4);
      check("restart_oe_run0", runs[0], 2);
      check("restart_r1_c1", r1_q[1], 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
